// File: rtl/hplvds_rx_lane_ctrl.sv
// rtl/hplvds_rx_lane_ctrl.sv - HPLVDS RX pad sequencer, per-lane EI filter and deserialiser
module hplvds_rx_lane_ctrl #(
    parameter int LANES      = 4,
    parameter int DES_W      = 8,
    parameter int SETTLE_CYC = 16,
    parameter int EI_FILT    = 4
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     EN_I,
    input  logic [LANES-1:0]         POL_I,
    input  logic [3:0]               TRIM_I,
    input  logic [LANES-1:0]         PAD_DI_I,
    input  logic [LANES-1:0]         PAD_EI_I,
    output logic                     PAD_RTERM_EN_O,
    output logic [3:0]               PAD_RTERM_TRIM_O,
    output logic                     PAD_VCM_EN_O,
    output logic                     PAD_RX_EN_O,
    output logic                     PAD_EI_EN_O,
    output logic [LANES-1:0]         PAD_RX_POL_O,
    output logic                     READY_O,
    output logic [LANES-1:0]         EI_O,
    output logic [LANES*DES_W-1:0]   DATA_O,
    output logic                     DATA_VLD_O
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int BW = $clog2(DES_W);
    localparam int EW = $clog2(EI_FILT + 1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_TERM   = 2'd1,
        ST_RXON   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [SW-1:0]                   settle_q, settle_d;
    logic                            term_en_q, term_en_d;
    logic                            rx_en_q, rx_en_d;
    logic                            ready_q, ready_d;
    logic [LANES-1:0]                pol_q;
    logic [BW-1:0]                   bit_q, bit_d;
    logic [LANES-1:0][DES_W-1:0]     shift_q, shift_d;
    logic [LANES*DES_W-1:0]          data_q, data_d;
    logic                            vld_q, vld_d;
    logic [LANES-1:0][EW-1:0]        eicnt_q, eicnt_d;
    logic [LANES-1:0]                ei_q, ei_d;
    logic                            des_run;
    logic                            filt_run;
    logic [DES_W-1:0]                word;

    // Power-up sequencer; outputs are registered from the next state
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q + SW'(1);
        unique case (state_q)
            ST_OFF:    if (EN_I) state_d = ST_TERM;
            ST_TERM:   if (settle_q == SW'(SETTLE_CYC - 1)) state_d = ST_RXON;
            ST_RXON:   if (settle_q == SW'(SETTLE_CYC - 1)) state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_OFF;
        endcase
        if (!EN_I) begin
            state_d = ST_OFF;
        end
        if (state_d != state_q || state_d == ST_OFF || state_d == ST_ACTIVE) begin
            settle_d = '0;
        end
        term_en_d = (state_d != ST_OFF);
        rx_en_d   = (state_d == ST_RXON) || (state_d == ST_ACTIVE);
        ready_d   = (state_d == ST_ACTIVE);
    end

    assign des_run  = (state_q == ST_ACTIVE) && EN_I;
    assign filt_run = ((state_q == ST_RXON) || (state_q == ST_ACTIVE)) && EN_I;

    // Deserialiser: LSB first, capture uses the EI flag as it stands on the capture cycle
    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        word    = '0;
        if (des_run) begin
            for (int l = 0; l < LANES; l++) begin
                word       = {PAD_DI_I[l], shift_q[l][DES_W-1:1]};
                shift_d[l] = word;
                if (bit_q == BW'(DES_W - 1)) begin
                    data_d[l*DES_W +: DES_W] = ei_q[l] ? '0 : word;
                end
            end
            if (bit_q == BW'(DES_W - 1)) begin
                bit_d = '0;
                vld_d = 1'b1;
            end else begin
                bit_d = bit_q + BW'(1);
            end
        end else begin
            bit_d   = '0;
            shift_d = '0;
        end
    end

    always_comb begin
        eicnt_d = '0;
        ei_d    = '0;
        for (int l = 0; l < LANES; l++) begin
            if (filt_run && PAD_EI_I[l]) begin
                eicnt_d[l] = (eicnt_q[l] == EW'(EI_FILT)) ? eicnt_q[l] : eicnt_q[l] + EW'(1);
            end
            ei_d[l] = (eicnt_d[l] == EW'(EI_FILT));
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= ST_OFF;
            settle_q  <= '0;
            term_en_q <= 1'b0;
            rx_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            pol_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            eicnt_q   <= '0;
            ei_q      <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            term_en_q <= term_en_d;
            rx_en_q   <= rx_en_d;
            ready_q   <= ready_d;
            pol_q     <= POL_I;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            eicnt_q   <= eicnt_d;
            ei_q      <= ei_d;
        end
    end

    assign PAD_RTERM_EN_O   = term_en_q;
    assign PAD_VCM_EN_O     = term_en_q;
    assign PAD_RTERM_TRIM_O = TRIM_I;
    assign PAD_RX_EN_O      = rx_en_q;
    assign PAD_EI_EN_O      = rx_en_q;
    assign PAD_RX_POL_O     = pol_q;
    assign READY_O          = ready_q;
    assign EI_O             = ei_q;
    assign DATA_O           = data_q;
    assign DATA_VLD_O       = vld_q;

endmodule

// File: tb/tb_hplvds_rx_lane_ctrl.sv
// tb/tb_hplvds_rx_lane_ctrl.sv - scoreboard bench for hplvds_rx_lane_ctrl
module tb_hplvds_rx_lane_ctrl;

    localparam int LANES  = 4;
    localparam int DES_W  = 8;
    localparam int SETTLE = 16;
    localparam int EIF    = 4;

    logic                   CLK_I = 1'b0;
    logic                   RST_I = 1'b1;
    logic                   EN_I = 1'b0;
    logic [LANES-1:0]       POL_I = '0;
    logic [3:0]             TRIM_I = '0;
    logic [LANES-1:0]       PAD_DI_I = '0;
    logic [LANES-1:0]       PAD_EI_I = '0;
    logic                   PAD_RTERM_EN_O;
    logic [3:0]             PAD_RTERM_TRIM_O;
    logic                   PAD_VCM_EN_O;
    logic                   PAD_RX_EN_O;
    logic                   PAD_EI_EN_O;
    logic [LANES-1:0]       PAD_RX_POL_O;
    logic                   READY_O;
    logic [LANES-1:0]       EI_O;
    logic [LANES*DES_W-1:0] DATA_O;
    logic                   DATA_VLD_O;

    always #5 CLK_I = ~CLK_I;

    hplvds_rx_lane_ctrl #(
        .LANES(LANES), .DES_W(DES_W), .SETTLE_CYC(SETTLE), .EI_FILT(EIF)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .POL_I(POL_I), .TRIM_I(TRIM_I),
        .PAD_DI_I(PAD_DI_I), .PAD_EI_I(PAD_EI_I),
        .PAD_RTERM_EN_O(PAD_RTERM_EN_O), .PAD_RTERM_TRIM_O(PAD_RTERM_TRIM_O),
        .PAD_VCM_EN_O(PAD_VCM_EN_O), .PAD_RX_EN_O(PAD_RX_EN_O), .PAD_EI_EN_O(PAD_EI_EN_O),
        .PAD_RX_POL_O(PAD_RX_POL_O), .READY_O(READY_O), .EI_O(EI_O),
        .DATA_O(DATA_O), .DATA_VLD_O(DATA_VLD_O)
    );

    int checks = 0;
    int errors = 0;
    logic [LANES*DES_W-1:0] sb_q[$];

    // Reference model: t_en counts consecutive enabled edges since power-down
    int                     t_en = 0;
    int                     nbits = 0;
    logic [DES_W-1:0]       acc[LANES];
    int                     run[LANES];
    logic [LANES-1:0]       ei_exp = '0;
    logic [LANES-1:0]       pol_exp = '0;
    logic [LANES*DES_W-1:0] data_exp = '0;
    bit                     started = 0;
    bit                     a5_pending = 0;
    int                     burst[LANES];
    bit                     lane2_ovr = 0;
    bit                     lane2_val = 0;
    logic [DES_W-1:0]       a5 = 8'hA5;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("rterm_en", 64'(PAD_RTERM_EN_O), 64'(t_en >= 1));
        chk("vcm_en",   64'(PAD_VCM_EN_O),   64'(t_en >= 1));
        chk("rx_en",    64'(PAD_RX_EN_O),    64'(t_en > SETTLE));
        chk("ei_en",    64'(PAD_EI_EN_O),    64'(t_en > SETTLE));
        chk("ready",    64'(READY_O),        64'(t_en > 2*SETTLE));
        chk("ei_o",     64'(EI_O),           64'(ei_exp));
        chk("rx_pol",   64'(PAD_RX_POL_O),   64'(pol_exp));
        chk("data_hold",64'(DATA_O),         64'(data_exp));
        chk("trim",     64'(PAD_RTERM_TRIM_O), 64'(TRIM_I));
    endtask

    task automatic model_clear();
        t_en = 0;
        nbits = 0;
        ei_exp = '0;
        for (int l = 0; l < LANES; l++) begin
            acc[l] = '0;
            run[l] = 0;
        end
    endtask

    task automatic model_step();
        if (RST_I) begin
            model_clear();
            pol_exp  = '0;
            data_exp = '0;
        end else if (!EN_I) begin
            model_clear();
            pol_exp = POL_I;
        end else begin
            if (t_en > 2*SETTLE) begin
                for (int l = 0; l < LANES; l++)
                    acc[l] = acc[l] | (DES_W'(PAD_DI_I[l]) << nbits);
                nbits++;
                if (nbits == DES_W) begin
                    for (int l = 0; l < LANES; l++)
                        data_exp[l*DES_W +: DES_W] = ei_exp[l] ? '0 : acc[l];
                    sb_q.push_back(data_exp);
                    nbits = 0;
                    for (int l = 0; l < LANES; l++) acc[l] = '0;
                    a5_pending = 0;
                end
            end
            if (t_en > SETTLE) begin
                for (int l = 0; l < LANES; l++) begin
                    run[l] = PAD_EI_I[l] ? run[l] + 1 : 0;
                    ei_exp[l] = (run[l] >= EIF);
                end
            end
            if (t_en < 100000) t_en++;
            pol_exp = POL_I;
        end
    endtask

    task automatic do_cycle(input bit rst, input bit en);
        logic [LANES-1:0] di;
        logic [LANES-1:0] ei;
        @(negedge CLK_I);
        if (started) check_outputs();
        started = 1;
        RST_I  = rst;
        EN_I   = en;
        TRIM_I = 4'($urandom);
        if ($urandom_range(0, 15) == 0) POL_I = POL_I ^ LANES'(1 << $urandom_range(0, LANES-1));
        di = LANES'($urandom);
        if (a5_pending && t_en > 2*SETTLE && en && !rst) di[0] = a5[nbits];
        for (int l = 0; l < LANES; l++) begin
            if (burst[l] > 0) begin
                ei[l] = 1'b1;
                burst[l]--;
            end else begin
                ei[l] = 1'b0;
                if ($urandom_range(0, 11) == 0) burst[l] = $urandom_range(1, 8);
            end
        end
        if (lane2_ovr) ei[2] = lane2_val;
        PAD_DI_I = di;
        PAD_EI_I = ei;
        model_step();
    endtask

    // Scoreboard monitor: every strobe must match the oldest predicted word
    always @(negedge CLK_I) begin
        if (started && DATA_VLD_O === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got data %0h expected no strobe at %0t", DATA_O, $time);
            end else begin
                logic [LANES*DES_W-1:0] exp;
                exp = sb_q.pop_front();
                if (DATA_O !== exp) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h at %0t", DATA_O, exp, $time);
                end
            end
        end
    end

    initial begin
        int guard;
        for (int l = 0; l < LANES; l++) begin
            burst[l] = 0;
            acc[l]   = '0;
            run[l]   = 0;
        end
        repeat (3) do_cycle(1, 0);
        repeat (2) do_cycle(0, 0);

        a5_pending = 1;
        repeat (60) do_cycle(0, 1);

        lane2_ovr = 1;
        lane2_val = 1; repeat (3) do_cycle(0, 1);
        lane2_val = 0; repeat (4) do_cycle(0, 1);
        lane2_val = 1; repeat (12) do_cycle(0, 1);
        lane2_val = 0; repeat (2) do_cycle(0, 1);
        lane2_ovr = 0;

        repeat (80) do_cycle(0, 1);

        guard = 0;
        while (nbits != 5 && guard < 50) begin
            do_cycle(0, 1);
            guard++;
        end
        if (nbits != 5) begin
            checks++;
            errors++;
            $display("FAIL mid_word_wait: got bit count %0d expected 5", nbits);
        end
        repeat (3) do_cycle(0, 0);
        a5_pending = 1;
        repeat (50) do_cycle(0, 1);

        repeat (40) do_cycle(0, 1);
        repeat (2) do_cycle(1, 1);
        a5_pending = 1;
        repeat (45) do_cycle(0, 1);
        repeat (30) do_cycle(0, 1);

        repeat (4) do_cycle(0, 0);
        @(negedge CLK_I);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
